hazard_sequencer: RTL and testbench

- Pipeline stall/flush controller for the 5-stage pipelined core.
- Detects load-use hazards that EX-stage forwarding cannot cover, and inserts LU_BUBBLES bubbles into ID/EX.
- Freezes the pipe on instruction/data memory busy, flushes IF/ID on EX-resolved redirects, and parks the core on halt.
- Drives every pipeline-register write enable, plus a saturating stall-cycle performance counter.

---
 rtl/hazard_sequencer.sv | 125 ++++++++++++
 tb/tb_hazard_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, memory freezes,
// redirect flushes, halt parking and a saturating stall-cycle counter.
module hazard_sequencer #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ID_rX,
  input  logic [2:0]       ID_rY,
  input  logic             ID_uses_X,
  input  logic             ID_uses_Y,
  input  logic [2:0]       EX_rO,
  input  logic             EX_rf_wen,
  input  logic             EX_is_load,
  input  logic             EX_redirect,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             WB_halt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  // state    | meaning
  // RUN      | normal issue, load-use detection active
  // LU_STALL | inserting the remaining load-use bubbles (lu_cnt_q left)
  // HALTED   | core parked until reset
  typedef enum logic [1:0] {RUN, LU_STALL, HALTED} state_e;

  localparam logic [1:0]       LU_INIT = 2'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu_hit;

  assign lu_hit = EX_is_load & EX_rf_wen &
                  ((ID_uses_X & (ID_rX == EX_rO)) | (ID_uses_Y & (ID_rY == EX_rO)));

  // Outputs are decoded from current inputs so a stall takes effect the same cycle.
  always_comb begin
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_wen   = 1'b0;
    memwb_wen   = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    if (!rst_n) begin
      state_d  = RUN;
      lu_cnt_d = 2'd0;
    end else if (state_q == HALTED) begin
      halted = 1'b1;
    end else if (WB_halt) begin
      state_d = HALTED;
    end else if (dmem_busy) begin
      state_d = state_q;
    end else if (EX_redirect) begin
      pc_wen      = 1'b1;
      ifid_wen    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
      state_d     = RUN;
      lu_cnt_d    = 2'd0;
    end else if ((state_q == LU_STALL) || lu_hit) begin
      idex_bubble = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
      if (state_q == LU_STALL) begin
        if (lu_cnt_q <= 2'd1) begin
          state_d  = RUN;
          lu_cnt_d = 2'd0;
        end else begin
          lu_cnt_d = lu_cnt_q - 2'd1;
        end
      end else if (LU_BUBBLES > 1) begin
        state_d  = LU_STALL;
        lu_cnt_d = LU_INIT;
      end
    end else if (imem_busy) begin
      ifid_wen   = 1'b1;
      ifid_flush = 1'b1;
      exmem_wen  = 1'b1;
      memwb_wen  = 1'b1;
    end else begin
      pc_wen    = 1'b1;
      ifid_wen  = 1'b1;
      exmem_wen = 1'b1;
      memwb_wen = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q != HALTED) && !WB_halt && !pc_wen && (stall_q != CNT_MAX))
      stall_d = stall_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      lu_cnt_q <= 2'd0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      stall_q  <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two instances (LU_BUBBLES=2/CNT_W=4 and LU_BUBBLES=3/CNT_W=16)
// share stimulus; decode table, directed corner sequences, then random vs a reference model.
module tb_hazard_sequencer;

  logic       clk, rst_n;
  logic [2:0] id_rx, id_ry, ex_ro;
  logic       uses_x, uses_y, ex_wen, ex_load, redir, imem, dmem, wb_halt;

  logic pc_a, ifid_a, fl_a, bub_a, ex_a, mw_a, h_a;
  logic pc_b, ifid_b, fl_b, bub_b, ex_b, mw_b, h_b;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;
  logic [6:0]  out_a, out_b;

  assign out_a = {pc_a, ifid_a, fl_a, bub_a, ex_a, mw_a, h_a};
  assign out_b = {pc_b, ifid_b, fl_b, bub_b, ex_b, mw_b, h_b};

  hazard_sequencer #(.LU_BUBBLES(2), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .ID_rX(id_rx), .ID_rY(id_ry), .ID_uses_X(uses_x),
    .ID_uses_Y(uses_y), .EX_rO(ex_ro), .EX_rf_wen(ex_wen), .EX_is_load(ex_load),
    .EX_redirect(redir), .imem_busy(imem), .dmem_busy(dmem), .WB_halt(wb_halt),
    .pc_wen(pc_a), .ifid_wen(ifid_a), .ifid_flush(fl_a), .idex_bubble(bub_a),
    .exmem_wen(ex_a), .memwb_wen(mw_a), .halted(h_a), .stall_cycles(stall_a));

  hazard_sequencer #(.LU_BUBBLES(3), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .ID_rX(id_rx), .ID_rY(id_ry), .ID_uses_X(uses_x),
    .ID_uses_Y(uses_y), .EX_rO(ex_ro), .EX_rf_wen(ex_wen), .EX_is_load(ex_load),
    .EX_redirect(redir), .imem_busy(imem), .dmem_busy(dmem), .WB_halt(wb_halt),
    .pc_wen(pc_b), .ifid_wen(ifid_b), .ifid_flush(fl_b), .idex_bubble(bub_b),
    .exmem_wen(ex_b), .memwb_wen(mw_b), .halted(h_b), .stall_cycles(stall_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output patterns {pc, ifid, flush, bubble, exmem, memwb, halted}
  localparam logic [6:0] O_NORM = 7'b1100110;
  localparam logic [6:0] O_LU   = 7'b0001110;
  localparam logic [6:0] O_IMEM = 7'b0110110;
  localparam logic [6:0] O_RDIR = 7'b1111110;
  localparam logic [6:0] O_ZERO = 7'b0000000;
  localparam logic [6:0] O_HALT = 7'b0000001;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rx = 3'd0; id_ry = 3'd0; ex_ro = 3'd0;
    uses_x = 1'b0; uses_y = 1'b0; ex_wen = 1'b0; ex_load = 1'b0;
    redir = 1'b0; imem = 1'b0; dmem = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic set_hit();
    ex_load = 1'b1; ex_wen = 1'b1; ex_ro = 3'd3; id_rx = 3'd3; uses_x = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reference model: pending bubble count, halt flag and a clamped integer counter.
  bit m_halt[2];
  int m_left[2];
  int m_cnt[2];
  int lub[2]  = '{2, 3};
  int cmax[2] = '{15, 65535};

  function automatic bit m_hit();
    return ex_load && ex_wen && ((uses_x && id_rx == ex_ro) || (uses_y && id_ry == ex_ro));
  endfunction

  function automatic logic [6:0] model_out(int k);
    if (!rst_n)             return O_ZERO;
    if (m_halt[k])          return O_HALT;
    if (wb_halt || dmem)    return O_ZERO;
    if (redir)              return O_RDIR;
    if (m_left[k] > 0 || m_hit()) return O_LU;
    if (imem)               return O_IMEM;
    return O_NORM;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_halt[k] = 1'b0; m_left[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [6:0] o;
    for (int k = 0; k < 2; k++) begin
      o = model_out(k);
      if (!rst_n) begin
        m_halt[k] = 1'b0; m_left[k] = 0; m_cnt[k] = 0;
      end else if (!m_halt[k]) begin
        if (!wb_halt && !o[6] && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (wb_halt)            m_halt[k] = 1'b1;
        else if (dmem)          ;
        else if (redir)         m_left[k] = 0;
        else if (m_left[k] > 0) m_left[k]--;
        else if (m_hit())       m_left[k] = lub[k] - 1;
      end
    end
  endtask

  typedef struct {
    logic [2:0] rx, ry, ro;
    logic       ux, uy, wen, ld, rd, im, dm, wh;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(logic [2:0] rx, logic ux, logic [2:0] ry, logic uy,
                              logic [2:0] ro, logic wen, logic ld, logic rd,
                              logic im, logic dm, logic wh, logic [6:0] exp);
    vec_t v;
    v.rx = rx; v.ux = ux; v.ry = ry; v.uy = uy; v.ro = ro; v.wen = wen; v.ld = ld;
    v.rd = rd; v.im = im; v.dm = dm; v.wh = wh; v.exp = exp;
    return v;
  endfunction

  vec_t vt[11];
  int   hcnt;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    //             rx  ux  ry  uy  ro  wen ld  rd  im  dm  wh
    vt[0]  = mk(3'd1, 1, 3'd2, 1, 3'd5, 1, 1, 0, 0, 0, 0, O_NORM);
    vt[1]  = mk(3'd3, 1, 3'd2, 1, 3'd3, 1, 1, 0, 0, 0, 0, O_LU);
    vt[2]  = mk(3'd3, 0, 3'd2, 1, 3'd3, 1, 1, 0, 0, 0, 0, O_NORM);
    vt[3]  = mk(3'd4, 1, 3'd0, 1, 3'd0, 1, 1, 0, 0, 0, 0, O_LU);
    vt[4]  = mk(3'd3, 1, 3'd3, 1, 3'd3, 0, 1, 0, 0, 0, 0, O_NORM);
    vt[5]  = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1, 0, 0, O_IMEM);
    vt[6]  = mk(3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 0, 1, 0, 0, O_LU);
    vt[7]  = mk(3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 1, 0, 0, 0, O_RDIR);
    vt[8]  = mk(3'd3, 1, 3'd0, 0, 3'd3, 1, 1, 1, 1, 1, 0, O_ZERO);
    vt[9]  = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1, 0, 1, O_ZERO);
    vt[10] = mk(3'd2, 1, 3'd2, 1, 3'd2, 1, 0, 0, 0, 0, 0, O_NORM);

    // Reset, then idle for 10 cycles
    @(negedge clk);
    #1 chk("reset_out_a", out_a, O_ZERO);
    chk("reset_out_b", out_b, O_ZERO);
    do_reset();
    repeat (10) step();
    #1 chk("idle_out_a", out_a, O_NORM);
    chk("idle_out_b", out_b, O_NORM);
    chk("idle_stall_a", stall_a, 0);
    chk("idle_stall_b", stall_b, 0);

    // Decode table in RUN; inputs drop back to idle before each edge
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      id_rx = vt[i].rx; uses_x = vt[i].ux; id_ry = vt[i].ry; uses_y = vt[i].uy;
      ex_ro = vt[i].ro; ex_wen = vt[i].wen; ex_load = vt[i].ld; redir = vt[i].rd;
      imem = vt[i].im; dmem = vt[i].dm; wb_halt = vt[i].wh;
      #1 chk($sformatf("table%0d_a", i), out_a, vt[i].exp);
      chk($sformatf("table%0d_b", i), out_b, vt[i].exp);
      #1 idle_inputs();
      @(negedge clk);
    end
    chk("table_stall_a", stall_a, 0);

    // Load-use: 2 bubbles on A, 3 on B
    do_reset();
    set_hit();
    #1 chk("lu_c0_a", out_a, O_LU);
    chk("lu_c0_b", out_b, O_LU);
    step(); idle_inputs();
    #1 chk("lu_c1_a", out_a, O_LU);
    chk("lu_c1_b", out_b, O_LU);
    step();
    #1 chk("lu_c2_a", out_a, O_NORM);
    chk("lu_c2_b", out_b, O_LU);
    step();
    #1 chk("lu_c3_b", out_b, O_NORM);
    chk("lu_stall_a", stall_a, 2);
    chk("lu_stall_b", stall_b, 3);
    set_hit(); uses_x = 1'b0;
    #1 chk("lu_nouse_a", out_a, O_NORM);
    chk("lu_nouse_b", out_b, O_NORM);

    // dmem_busy freeze in the middle of a load-use stall
    do_reset();
    set_hit();
    step(); idle_inputs(); dmem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dm_frozen_a", out_a, O_ZERO);
      chk("dm_frozen_b", out_b, O_ZERO);
      step();
    end
    dmem = 1'b0;
    #1 chk("dm_bub1_a", out_a, O_LU);
    chk("dm_bub1_b", out_b, O_LU);
    step();
    #1 chk("dm_after_a", out_a, O_NORM);
    chk("dm_bub2_b", out_b, O_LU);
    step();
    #1 chk("dm_after_b", out_b, O_NORM);
    chk("dm_stall_a", stall_a, 5);
    chk("dm_stall_b", stall_b, 6);

    // Redirect and load-use in the same cycle
    do_reset();
    set_hit(); redir = 1'b1;
    #1 chk("rd_lu_a", out_a, O_RDIR);
    chk("rd_lu_b", out_b, O_RDIR);
    step(); idle_inputs();
    #1 chk("rd_next_a", out_a, O_NORM);
    chk("rd_next_b", out_b, O_NORM);
    chk("rd_stall_a", stall_a, 0);

    // Halt while fetch is busy; random inputs cannot unpark it
    do_reset();
    wb_halt = 1'b1; imem = 1'b1;
    #1 chk("halt_c0_a", out_a, O_ZERO);
    chk("halt_c0_b", out_b, O_ZERO);
    step();
    for (int i = 0; i < 20; i++) begin
      wb_halt = 1'b0;
      {redir, imem, dmem, ex_load, ex_wen, uses_x} = 6'($urandom);
      #1 chk("halt_park_a", out_a, O_HALT);
      chk("halt_park_b", out_b, O_HALT);
      step();
    end
    chk("halt_stall_a", stall_a, 0);
    chk("halt_stall_b", stall_b, 0);
    do_reset();
    #1 chk("halt_clear_a", out_a, O_NORM);

    // Counter saturation on the 4-bit instance
    do_reset();
    imem = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1 chk("sat_flush_a", out_a, O_IMEM);
      step();
    end
    chk("sat_stall_a", stall_a, 15);
    chk("sat_stall_b", stall_b, 20);

    // Asynchronous reset in the middle of a load-use stall
    do_reset();
    set_hit();
    step(); idle_inputs();
    #2 rst_n = 1'b0;
    #1 chk("arst_out_a", out_a, O_ZERO);
    chk("arst_out_b", out_b, O_ZERO);
    chk("arst_stall_b", stall_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_run_a", out_a, O_NORM);
    chk("arst_run_b", out_b, O_NORM);

    // Random stimulus against the reference model
    do_reset();
    model_reset();
    hcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      id_rx = 3'($urandom_range(0, 3)); id_ry = 3'($urandom_range(0, 3));
      ex_ro = 3'($urandom_range(0, 3));
      uses_x = 1'($urandom); uses_y = 1'($urandom);
      ex_load = 1'($urandom); ex_wen = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 7) == 0);
      imem = ($urandom_range(0, 4) == 0);
      dmem = ($urandom_range(0, 5) == 0);
      wb_halt = ($urandom_range(0, 99) == 0);
      hcnt = m_halt[0] ? hcnt + 1 : 0;
      rst_n = !(($urandom_range(0, 99) == 0) || hcnt > 25);
      if (!rst_n) model_reset();
      #1 chk("rand_out_a", out_a, model_out(0));
      chk("rand_out_b", out_b, model_out(1));
      chk("rand_stall_a", stall_a, m_cnt[0]);
      chk("rand_stall_b", stall_b, m_cnt[1]);
      model_step();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
